// File: rtl/prog_clk_divider.sv
// Programmable 50%-duty clock divider (ratio 1..2^WIDTH-1) with enable, clean stop and
// boundary-only ratio changes. Define FDIV_PERIOD_TICK_EN to add the period_tick output.
`timescale 1ns/1ps
module prog_clk_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  output logic [WIDTH-1:0] active_div,
  output logic [WIDTH-1:0] pos_count,
  output logic [WIDTH-1:0] neg_count,
  output logic             running,
  output logic             clk_out
`ifdef FDIV_PERIOD_TICK_EN
  ,
  output logic             period_tick
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ncnt_q;
  logic             run_q, run_d;
  logic             hi_q, hi_d;
  logic             nhi_q;
  logic             byp_q, byp_d;
  logic             gate_q;
  logic             boundary;
  logic [WIDTH:0]   half_d;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    boundary = (state_q != StIdle) &&
               (({1'b0, cnt_q} + (WIDTH+1)'(1)) == {1'b0, div_q});
    unique case (state_q)
      StIdle: begin
        div_d = '0;
        cnt_d = '0;
        if (en && (div_val != '0)) begin
          state_d = StRun;
          div_d   = div_val;
        end
      end
      StRun, StDrain: begin
        if (boundary) begin
          cnt_d = '0;
          if (!en || (div_val == '0)) begin
            state_d = StIdle;
            div_d   = '0;
          end else begin
            state_d = StRun;
            div_d   = div_val;
          end
        end else begin
          cnt_d   = cnt_q + WIDTH'(1);
          state_d = en ? StRun : StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
    run_d  = (state_d != StIdle);
    byp_d  = run_d && (div_d == WIDTH'(1));
    // Posedge phase is high for floor(D/2) cycles; odd ratios get the extra half from nhi_q.
    half_d = {1'b0, div_d} >> 1;
    hi_d   = run_d && ({1'b0, cnt_d} < half_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      hi_q    <= 1'b0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      hi_q    <= hi_d;
      byp_q   <= byp_d;
    end
  end

  // Bypass gate changes only while clk is low, so clk & gate_q never produces a runt.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      ncnt_q <= '0;
      nhi_q  <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      ncnt_q <= cnt_q;
      nhi_q  <= hi_q;
      gate_q <= byp_q;
    end
  end

`ifdef FDIV_PERIOD_TICK_EN
  logic tick_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= boundary;
    end
  end

  assign period_tick = tick_q;
`endif

  assign active_div = div_q;
  assign pos_count  = cnt_q;
  assign neg_count  = ncnt_q;
  assign running    = run_q;
  assign clk_out    = hi_q | (div_q[0] & nhi_q) | (clk & gate_q);

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: directed vector table, timed pulse measurements,
// mid-period reset, and randomized run against a half-cycle-level reference model.
`timescale 1ns/1ps
module tb_prog_clk_divider;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] div_val = '0;
  logic [W-1:0] active_div, pos_count, neg_count;
  logic         running, clk_out;
`ifdef FDIV_PERIOD_TICK_EN
  logic         period_tick;
`endif

  prog_clk_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .div_val    (div_val),
    .active_div (active_div),
    .pos_count  (pos_count),
    .neg_count  (neg_count),
    .running    (running),
    .clk_out    (clk_out)
`ifdef FDIV_PERIOD_TICK_EN
    ,
    .period_tick(period_tick)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Reference model: m_k is the cycle index inside the current period of ratio m_d;
  // half-cycle h = 2*m_k (+1) is high while h < D. Bypass output follows the previous cycle.
  bit m_run, m_byp_prev, m_tick;
  int m_d, m_k;

  task automatic model_reset();
    m_run = 0; m_d = 0; m_k = 0; m_byp_prev = 0; m_tick = 0;
  endtask

  task automatic model_edge(input bit e, input int dv);
    bit bnd;
    bnd        = m_run && (m_k == m_d - 1);
    m_byp_prev = m_run && (m_d == 1);
    m_tick     = bnd;
    if (!m_run) begin
      if (e && dv != 0) begin m_run = 1; m_d = dv; m_k = 0; end
    end else if (bnd) begin
      m_k = 0;
      if (!e || dv == 0) begin m_run = 0; m_d = 0; end
      else m_d = dv;
    end else begin
      m_k++;
    end
  endtask

  function automatic bit exp_out(input bit second);
    int h;
    h = 2 * m_k + (second ? 1 : 0);
    return (m_run && m_d >= 2 && h < m_d) || (!second && m_byp_prev);
  endfunction

  // Entered and left at negedge+3.
  task automatic cycle_model(input bit e, input int dv);
    en = e; div_val = W'(dv);
    @(posedge clk);
    model_edge(e, dv);
    #2;
    chk("clk_out_high_phase", clk_out, exp_out(0));
    chk("pos_count", pos_count, m_k);
    chk("active_div", active_div, m_d);
    chk("running", running, m_run);
`ifdef FDIV_PERIOD_TICK_EN
    chk("period_tick", period_tick, m_tick);
`endif
    @(negedge clk);
    #2;
    chk("clk_out_low_phase", clk_out, exp_out(1));
    chk("neg_count", neg_count, m_k);
    #1;
  endtask

  task automatic wait_lvl(input bit v, output realtime t, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (clk_out === v) begin ok = 1; break; end
      #1;
    end
    t = $realtime;
  endtask

  task automatic measure(input string name, input int exp_hi, input int exp_per);
    realtime t0, t1, t2, tx;
    bit ok0, ok1, ok2, ok3;
    wait_lvl(0, tx, ok0);
    wait_lvl(1, t0, ok1);
    wait_lvl(0, t1, ok2);
    wait_lvl(1, t2, ok3);
    chk({name, "_edges_seen"}, {31'd0, ok0 & ok1 & ok2 & ok3}, 1);
    chk({name, "_high_ns"}, int'(t1 - t0), exp_hi);
    chk({name, "_period_ns"}, int'(t2 - t0), exp_per);
  endtask

  typedef struct {
    bit e; int dv; int pc; int ad; bit rn; bit hi; bit lo; bit tk;
  } vec_t;
  vec_t tbl [0:22];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdv;
    bit ren;
    //          e  dv pc ad rn hi lo tk
    tbl = '{'{1, 6, 0, 6, 1, 1, 1, 0}, '{1, 6, 1, 6, 1, 1, 1, 0}, '{1, 3, 2, 6, 1, 1, 1, 0},
            '{1, 3, 3, 6, 1, 0, 0, 0}, '{1, 3, 4, 6, 1, 0, 0, 0}, '{1, 3, 5, 6, 1, 0, 0, 0},
            '{1, 3, 0, 3, 1, 1, 1, 1}, '{1, 3, 1, 3, 1, 1, 0, 0}, '{1, 3, 2, 3, 1, 0, 0, 0},
            '{1, 4, 0, 4, 1, 1, 1, 1}, '{0, 4, 1, 4, 1, 1, 1, 0}, '{0, 4, 2, 4, 1, 0, 0, 0},
            '{0, 4, 3, 4, 1, 0, 0, 0}, '{0, 4, 0, 0, 0, 0, 0, 1}, '{0, 4, 0, 0, 0, 0, 0, 0},
            '{1, 4, 0, 4, 1, 1, 1, 0}, '{1, 5, 1, 4, 1, 1, 1, 0}, '{1, 5, 2, 4, 1, 0, 0, 0},
            '{1, 5, 3, 4, 1, 0, 0, 0}, '{1, 5, 0, 5, 1, 1, 1, 1}, '{1, 5, 1, 5, 1, 1, 1, 0},
            '{1, 5, 2, 5, 1, 1, 0, 0}, '{1, 5, 3, 5, 1, 0, 0, 0}};

    // Reset state
    #3;
    chk("reset_pos_count", pos_count, 0);
    chk("reset_neg_count", neg_count, 0);
    chk("reset_active_div", active_div, 0);
    chk("reset_running", running, 0);
    chk("reset_clk_out", clk_out, 0);
`ifdef FDIV_PERIOD_TICK_EN
    chk("reset_period_tick", period_tick, 0);
`endif
    #9 reset = 1'b1;
    #1;

    // Directed table: D=6 start, 6->3 mid-period change, 3->4, en drop at pos_count=1, restart
    for (int i = 0; i < 23; i++) begin
      en = tbl[i].e; div_val = W'(tbl[i].dv);
      @(posedge clk);
      #2;
      chk($sformatf("tbl%0d_clk_out_high", i), clk_out, tbl[i].hi);
      chk($sformatf("tbl%0d_pos_count", i), pos_count, tbl[i].pc);
      chk($sformatf("tbl%0d_active_div", i), active_div, tbl[i].ad);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].rn);
`ifdef FDIV_PERIOD_TICK_EN
      chk($sformatf("tbl%0d_period_tick", i), period_tick, tbl[i].tk);
`endif
      @(negedge clk);
      #2;
      chk($sformatf("tbl%0d_clk_out_low", i), clk_out, tbl[i].lo);
      chk($sformatf("tbl%0d_neg_count", i), neg_count, tbl[i].pc);
      #1;
    end

    // Timed pulse shapes: odd ratios get exactly D/2 periods high
    #0.5;
    measure("d5", 25, 50);
    div_val = 4'd15;
    measure("d15", 75, 150);
    div_val = 4'd1;
    measure("d1", 5, 10);
    @(negedge clk);
    #3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2 chk("d1_mirror_high", clk_out, 1);
      @(negedge clk);
      #2 chk("d1_mirror_low", clk_out, 0);
      #1;
    end
    div_val = 4'd4;
    #0.5;
    measure("d1_to_d4", 20, 40);

    // Reset mid-high with D=7
    @(negedge clk);
    #3 reset = 1'b0;
    #4 reset = 1'b1;
    @(negedge clk);
    #3;
    model_reset();
    cycle_model(1, 7);
    cycle_model(1, 7);
    reset = 1'b0;
    #1;
    chk("midreset_clk_out", clk_out, 0);
    chk("midreset_pos_count", pos_count, 0);
    chk("midreset_neg_count", neg_count, 0);
    chk("midreset_running", running, 0);
    chk("midreset_active_div", active_div, 0);
    #3 reset = 1'b1;
    @(negedge clk);
    #3;
    model_reset();
    for (int i = 0; i < 16; i++) cycle_model(1, 7);

    // Randomized run against the model
    rdv = 7;
    ren = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        rdv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      if ($urandom_range(0, 15) == 0) ren = !ren;
      cycle_model(ren, rdv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
